// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential NxN matrix multiplier C = A*B with one shared MAC.
// Define MATRIX_MULT_SIGNED_EN for two's-complement operands and results.
module matrix_mult_seq #(
    parameter int N = 3,
    parameter int DATA_W = 8,
    localparam int ACC_W = 2 * DATA_W + $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              done,
    output logic              busy
);

    localparam int NN = N * N;
    localparam int IW = $clog2(N);
    localparam int AW = $clog2(NN);
    localparam int BW = $clog2(2 * NN);
    localparam int PW = 2 * DATA_W;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(2 * NN - 1);
    localparam logic [BW-1:0] B_BASE    = BW'(NN);

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_OUT
    } state_t;

    state_t state, state_nx;

    logic [BW-1:0]     beat;
    logic [IW-1:0]     i_idx, j_idx, k_idx;
    logic [ACC_W-1:0]  acc, sum, prod_ext;
    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] mem_a [NN];
    logic [DATA_W-1:0] mem_b [NN];
    logic [DATA_W-1:0] op_a, op_b;
    logic [AW-1:0]     a_idx, b_idx, wr_idx;
    logic              beat_acc, out_hs, last_elem;

    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_LOAD);
    assign last_elem = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);
    assign out_last  = out_valid & last_elem;
    assign beat_acc  = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    assign wr_idx = (beat < B_BASE) ? AW'(beat) : AW'(beat - B_BASE);
    assign a_idx  = AW'(i_idx) * AW'(N) + AW'(k_idx);
    assign b_idx  = AW'(k_idx) * AW'(N) + AW'(j_idx);
    assign op_a   = mem_a[a_idx];
    assign op_b   = mem_b[b_idx];

`ifdef MATRIX_MULT_SIGNED_EN
    assign prod = {{DATA_W{op_a[DATA_W-1]}}, op_a}
                * {{DATA_W{op_b[DATA_W-1]}}, op_b};
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
`else
    assign prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
    assign prod_ext = {{(ACC_W - PW){1'b0}}, prod};
`endif

    assign sum = acc + prod_ext;

    // Operand storage: A beats first, then B, both row-major; never reset.
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            if (beat < B_BASE) begin
                mem_a[wr_idx] <= in_data;
            end else begin
                mem_b[wr_idx] <= in_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: load all beats, N MAC cycles per element, hold until accepted.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_LOAD: begin
                if (beat_acc && (beat == LAST_BEAT)) begin
                    state_nx = S_MAC;
                end
            end
            S_MAC: begin
                if (k_idx == LAST_IDX) begin
                    state_nx = S_OUT;
                end
            end
            S_OUT: begin
                if (out_hs) begin
                    state_nx = last_elem ? S_LOAD : S_MAC;
                end
            end
            default: state_nx = S_LOAD;
        endcase
    end

    // Counters, accumulator, held result and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat     <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            k_idx    <= '0;
            acc      <= '0;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_LOAD: begin
                    if (beat_acc) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            i_idx <= '0;
                            j_idx <= '0;
                            k_idx <= '0;
                            acc   <= '0;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                S_MAC: begin
                    if (k_idx == LAST_IDX) begin
                        out_data <= sum;
                        acc      <= '0;
                        k_idx    <= '0;
                    end else begin
                        acc   <= sum;
                        k_idx <= k_idx + IW'(1);
                    end
                end
                S_OUT: begin
                    if (out_hs) begin
                        if (last_elem) begin
                            i_idx <= '0;
                            j_idx <= '0;
                            done  <= 1'b1;
                        end else if (j_idx == LAST_IDX) begin
                            j_idx <= '0;
                            i_idx <= i_idx + IW'(1);
                        end else begin
                            j_idx <= j_idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
